scope_trace_renderer: RTL and testbench

- Pixel-colour source feeding the 640x480 VGA timing/pixel-drawing stage of the DE1-SoC scope.
- Captures a triggered 640-sample record of 8-bit ADC data into a double-buffered line store.
- For each requested (x,y) display position, returns 8-bit R/G/B: the waveform trace over a graticule, on a black background.

---
 rtl/scope_pkg.sv | 25 ++
 rtl/scope_line_buffer.sv | 38 +++
 rtl/scope_trace_renderer.sv | 205 ++++++++++++++++++++
 tb/tb_scope_trace_renderer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trace renderer.
package scope_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int GRID_X       = 64;
  localparam int GRID_Y       = 48;

  localparam logic [23:0] TRACE_RGB = 24'h00FF00;
  localparam logic [23:0] GRID_RGB  = 24'h404040;
  localparam logic [23:0] BLACK_RGB = 24'h000000;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    FULL      = 2'd3
  } cap_state_e;

  // Display row of a sample: larger samples sit higher on screen.
  function automatic logic [9:0] sample_row(input logic [9:0] offset, input logic [7:0] s);
    return offset + 10'd255 - {2'b00, s};
  endfunction

endpackage

// File: rtl/scope_line_buffer.sv
// Dual-bank line store: one bank is written by capture while the other is
// read for display. The renderer needs column x and x-1 in the same cycle,
// so there are two synchronous read ports on the display bank.
module scope_line_buffer #(
  parameter int DEPTH = 640
) (
  input  logic       clock,
  input  logic       wr_bank,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [9:0] rd_addr_a,
  input  logic [9:0] rd_addr_b,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b
);

  logic [7:0] mem0 [0:DEPTH-1];
  logic [7:0] mem1 [0:DEPTH-1];
  logic [7:0] rd_a_q;
  logic [7:0] rd_b_q;

  // Write into the bank currently owned by capture.
  always_ff @(posedge clock) begin
    if (wr_en && !wr_bank) mem0[wr_addr] <= wr_data;
    if (wr_en && wr_bank)  mem1[wr_addr] <= wr_data;
  end

  // One-cycle registered reads from the bank not being written.
  always_ff @(posedge clock) begin
    rd_a_q <= wr_bank ? mem0[rd_addr_a] : mem1[rd_addr_a];
    rd_b_q <= wr_bank ? mem0[rd_addr_b] : mem1[rd_addr_b];
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;

endmodule

// File: rtl/scope_trace_renderer.sv
// Scope trace renderer: triggered capture of a 640-sample record into a
// double-buffered line store, plus a 2-cycle pixel colour pipeline.
// Optional auto-trigger enabled by defining SCOPE_AUTOTRIG_EN.
//
// state     | meaning
// ARM       | waiting for first accepted sample to seed the previous-sample reg
// WAIT_TRIG | looking for a level crossing (armed = 1)
// CAPTURE   | writing accepted samples at idx 1..639
// FULL      | record complete, waiting for frame_start to swap banks
module scope_trace_renderer
  import scope_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int TRACE_OFFSET = 112,
  parameter int DECIM        = 1,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic [7:0] trig_level,
  input  logic       trig_rising,
  input  logic       frame_start,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  output logic [7:0] colour_R,
  output logic [7:0] colour_G,
  output logic [7:0] colour_B,
  output logic       armed,
  output logic       record_ready
);

  if (DECIM < 1 || DECIM > 255 || AUTO_TIMEOUT < 1) begin : g_param_check
    $error("scope_trace_renderer: DECIM or AUTO_TIMEOUT out of range");
  end

  cap_state_e state_q, state_d;
  logic       wbank_q, wbank_d;
  logic       disp_valid_q, disp_valid_d;
  logic [7:0] dec_q, dec_d;
  logic [9:0] idx_q, idx_d;
  logic [7:0] prev_q, prev_d;
  logic       armed_q, armed_d;
  logic       rr_q, rr_d;
`ifdef SCOPE_AUTOTRIG_EN
  logic [15:0] to_q, to_d;
`endif

  logic       accept;
  logic       trig_hit;
  logic       auto_hit;
  logic       wr_en;
  logic [9:0] wr_addr;

  // Capture FSM next-state, decimation and write-port control.
  always_comb begin
    accept   = sample_valid && (dec_q == 8'(DECIM - 1));
    dec_d    = dec_q;
    if (sample_valid) dec_d = accept ? 8'd0 : dec_q + 8'd1;
    trig_hit = trig_rising ? ((prev_q < trig_level) && (sample_data >= trig_level))
                           : ((prev_q >= trig_level) && (sample_data < trig_level));
    auto_hit     = 1'b0;
    state_d      = state_q;
    wbank_d      = wbank_q;
    disp_valid_d = disp_valid_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    wr_en        = 1'b0;
    wr_addr      = idx_q;
`ifdef SCOPE_AUTOTRIG_EN
    to_d = to_q;
`endif
    case (state_q)
      ARM: if (accept) begin
        prev_d  = sample_data;
        state_d = WAIT_TRIG;
`ifdef SCOPE_AUTOTRIG_EN
        to_d = 16'd0;
`endif
      end
      WAIT_TRIG: if (accept) begin
        prev_d = sample_data;
`ifdef SCOPE_AUTOTRIG_EN
        to_d     = to_q + 16'd1;
        auto_hit = (to_q == 16'(AUTO_TIMEOUT - 1));
`endif
        if (trig_hit || auto_hit) begin
          wr_en   = 1'b1;
          wr_addr = 10'd0;
          idx_d   = 10'd1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: if (accept) begin
        wr_en = 1'b1;
        idx_d = idx_q + 10'd1;
        if (idx_q == 10'(H_ACTIVE - 1)) state_d = FULL;
      end
      FULL: if (frame_start) begin
        wbank_d      = ~wbank_q;
        disp_valid_d = 1'b1;
        idx_d        = 10'd0;
        state_d      = ARM;
      end
    endcase
    armed_d = (state_d == WAIT_TRIG);
    rr_d    = (state_d == FULL);
  end

  // Capture FSM state and its registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARM;
      wbank_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      dec_q        <= 8'd0;
      idx_q        <= 10'd0;
      prev_q       <= 8'd0;
      armed_q      <= 1'b0;
      rr_q         <= 1'b0;
`ifdef SCOPE_AUTOTRIG_EN
      to_q         <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      wbank_q      <= wbank_d;
      disp_valid_q <= disp_valid_d;
      dec_q        <= dec_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      rr_q         <= rr_d;
`ifdef SCOPE_AUTOTRIG_EN
      to_q         <= to_d;
`endif
    end
  end

  assign armed        = armed_q;
  assign record_ready = rr_q;

  logic [7:0] s_cur, s_prev;
  logic [9:0] rd_prev_addr;

  assign rd_prev_addr = (pix_x == 10'd0) ? 10'd0 : pix_x - 10'd1;

  scope_line_buffer #(.DEPTH(H_ACTIVE)) u_line_buffer (
    .clock     (clock),
    .wr_bank   (wbank_q),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (sample_data),
    .rd_addr_a (pix_x),
    .rd_addr_b (rd_prev_addr),
    .rd_data_a (s_cur),
    .rd_data_b (s_prev)
  );

  logic [9:0]  x1_q, x1_d, y1_q, y1_d;
  logic        act1_q, act1_d;
  logic [23:0] colour_q, colour_d;
  logic [9:0]  cur_row, prev_row, row_lo, row_hi;
  logic        hit, grid;

  // Stage-2 colour: trace over graticule over black.
  always_comb begin
    x1_d     = pix_x;
    y1_d     = pix_y;
    act1_d   = pix_active;
    cur_row  = sample_row(10'(TRACE_OFFSET), s_cur);
    prev_row = sample_row(10'(TRACE_OFFSET), s_prev);
    row_lo   = (cur_row < prev_row) ? cur_row : prev_row;
    row_hi   = (cur_row < prev_row) ? prev_row : cur_row;
    hit      = disp_valid_q && (y1_q >= row_lo) && (y1_q <= row_hi);
    grid     = ((x1_q % 10'(GRID_X)) == 10'd0) || ((y1_q % 10'(GRID_Y)) == 10'd0) ||
               (x1_q == 10'(H_ACTIVE - 1)) || (y1_q == 10'(V_ACTIVE - 1));
    if (!act1_q)   colour_d = BLACK_RGB;
    else if (hit)  colour_d = TRACE_RGB;
    else if (grid) colour_d = GRID_RGB;
    else           colour_d = BLACK_RGB;
  end

  // Render pipeline registers: request alongside RAM read, then colour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x1_q     <= 10'd0;
      y1_q     <= 10'd0;
      act1_q   <= 1'b0;
      colour_q <= BLACK_RGB;
    end else begin
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      act1_q   <= act1_d;
      colour_q <= colour_d;
    end
  end

  assign colour_R = colour_q[23:16];
  assign colour_G = colour_q[15:8];
  assign colour_B = colour_q[7:0];

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Directed bench for scope_trace_renderer (default build) plus a DECIM=4 instance.
module tb_scope_trace_renderer;

  localparam logic [23:0] G = 24'h00FF00;
  localparam logic [23:0] W = 24'h404040;
  localparam logic [23:0] K = 24'h000000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'd0;
  logic [7:0] trig_level = 8'd128;
  logic       trig_rising = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic       pix_active = 1'b0;
  logic [7:0] colour_R, colour_G, colour_B;
  logic       armed, record_ready;

  logic       sample_valid4 = 1'b0;
  logic       frame_start4 = 1'b0;
  logic [7:0] colour4_R, colour4_G, colour4_B;
  logic       armed4, record_ready4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  scope_trace_renderer u_dut (
    .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_rising(trig_rising), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .colour_R(colour_R), .colour_G(colour_G), .colour_B(colour_B),
    .armed(armed), .record_ready(record_ready)
  );

  scope_trace_renderer #(.DECIM(4)) u_dut_d4 (
    .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid4), .sample_data(sample_data),
    .trig_level(trig_level), .trig_rising(trig_rising), .frame_start(frame_start4),
    .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
    .colour_R(colour4_R), .colour_G(colour4_G), .colour_B(colour4_B),
    .armed(armed4), .record_ready(record_ready4)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic act, input logic [23:0] exp,
                     input string tag);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_active = act;
    tick;
    tick;
    check(tag, {colour_R, colour_G, colour_B}, exp);
    pix_active = 1'b0;
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample_data = 8'(v);
    tick;
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (3) tick;
    check("rst_colour", {colour_R, colour_G, colour_B}, K);
    check("rst_armed", {23'd0, armed}, 24'd0);
    check("rst_ready", {23'd0, record_ready}, 24'd0);
    reset_n = 1'b1;
    tick;

    // Graticule only, nothing captured yet
    pix(64, 100, 1'b1, W, "grid_64_100");
    pix(63, 100, 1'b1, K, "blank_63_100");
    pix(639, 5, 1'b1, W, "grid_x639");
    pix(5, 479, 1'b1, W, "grid_y479");
    pix(10, 48, 1'b1, W, "grid_y48");
    pix(64, 96, 1'b0, K, "inactive");
    check("armed_before_sample", {23'd0, armed}, 24'd0);

    // Record 1: rising ramp, trigger on 128
    trig_level = 8'd128;
    trig_rising = 1'b1;
    send(0);
    check("armed_after_first", {23'd0, armed}, 24'd1);
    for (int i = 1; i < 128; i++) send(i);
    check("armed_before_trig", {23'd0, armed}, 24'd1);
    send(128);
    check("armed_after_trig", {23'd0, armed}, 24'd0);
    for (int i = 129; i < 767; i++) begin
      frame_start = (i == 400);
      send(i);
      frame_start = 1'b0;
    end
    check("ready_at_639", {23'd0, record_ready}, 24'd0);
    send(767);
    check("ready_at_640", {23'd0, record_ready}, 24'd1);
    pix(1, 238, 1'b1, K, "no_swap_yet");

    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    check("ready_after_swap", {23'd0, record_ready}, 24'd0);

    pix(0, 239, 1'b1, G, "r1_c0_239");
    pix(0, 238, 1'b1, W, "r1_c0_238");
    pix(1, 238, 1'b1, G, "r1_c1_238");
    pix(1, 239, 1'b1, G, "r1_c1_239");
    pix(1, 237, 1'b1, K, "r1_c1_237");
    pix(128, 200, 1'b1, G, "r1_c128_200");
    pix(128, 112, 1'b1, G, "r1_c128_112");
    pix(129, 367, 1'b1, G, "r1_c129_367");
    pix(129, 365, 1'b1, K, "r1_c129_365");

    // Record 2: falling trigger, step 0->255 between columns 9 and 10
    trig_rising = 1'b0;
    send(200);
    check("r2_armed", {23'd0, armed}, 24'd1);
    send(0);
    check("r2_trig", {23'd0, armed}, 24'd0);
    repeat (9) send(0);
    repeat (300) send(255);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    pix(1, 238, 1'b1, G, "held_c1_238");
    pix(128, 200, 1'b1, G, "held_c128_200");
    check("held_not_ready", {23'd0, record_ready}, 24'd0);
    repeat (329) send(255);
    check("r2_ready_639", {23'd0, record_ready}, 24'd0);
    send(255);
    check("r2_ready_640", {23'd0, record_ready}, 24'd1);
    pix(0, 239, 1'b1, G, "full_still_r1");

    // Swap and sample in the same cycle: swap wins
    sample_valid = 1'b1;
    sample_data = 8'd0;
    frame_start = 1'b1;
    tick;
    sample_valid = 1'b0;
    frame_start = 1'b0;
    check("swap_ready", {23'd0, record_ready}, 24'd0);
    check("swap_armed", {23'd0, armed}, 24'd0);

    pix(10, 112, 1'b1, G, "r2_c10_112");
    pix(10, 200, 1'b1, G, "r2_c10_200");
    pix(10, 367, 1'b1, G, "r2_c10_367");
    pix(10, 111, 1'b1, K, "r2_c10_111");
    pix(10, 368, 1'b1, K, "r2_c10_368");
    pix(9, 367, 1'b1, G, "r2_c9_367");
    pix(9, 366, 1'b1, K, "r2_c9_366");
    pix(9, 112, 1'b1, K, "r2_c9_112");
    pix(11, 112, 1'b1, G, "r2_c11_112");
    pix(11, 113, 1'b1, K, "r2_c11_113");
    pix(0, 367, 1'b1, G, "r2_c0_367");
    pix(0, 366, 1'b1, W, "r2_c0_366");
    pix(639, 113, 1'b1, W, "r2_c639_113");
    pix(64, 96, 1'b1, W, "r2_grid_64_96");

    // Reset mid-capture discards the display
    send(200);
    send(0);
    repeat (20) send(0);
    pix(9, 367, 1'b1, G, "pre_reset_trace");
    reset_n = 1'b0;
    #2;
    check("midrst_colour", {colour_R, colour_G, colour_B}, K);
    check("midrst_ready", {23'd0, record_ready}, 24'd0);
    tick;
    reset_n = 1'b1;
    tick;
    pix(9, 367, 1'b1, K, "no_trace_after_rst");
    pix(64, 200, 1'b1, W, "grid_after_rst");
    send(5);
    check("rearm_after_rst", {23'd0, armed}, 24'd1);

    // DECIM = 4 instance, sample_valid held high
    trig_rising = 1'b0;
    trig_level = 8'd128;
    sample_valid4 = 1'b1;
    sample_data = 8'd200;
    repeat (3) tick;
    check("d4_armed_c3", {23'd0, armed4}, 24'd0);
    tick;
    check("d4_armed_c4", {23'd0, armed4}, 24'd1);
    sample_data = 8'd0;
    repeat (3) tick;
    check("d4_armed_c7", {23'd0, armed4}, 24'd1);
    tick;
    check("d4_trig_c8", {23'd0, armed4}, 24'd0);
    repeat (2555) tick;
    check("d4_ready_early", {23'd0, record_ready4}, 24'd0);
    tick;
    check("d4_ready", {23'd0, record_ready4}, 24'd1);
    sample_valid4 = 1'b0;
    frame_start4 = 1'b1;
    tick;
    frame_start4 = 1'b0;
    pix_x = 10'd5;
    pix_y = 10'd367;
    pix_active = 1'b1;
    tick;
    tick;
    check("d4_c5_367", {colour4_R, colour4_G, colour4_B}, G);
    pix_y = 10'd366;
    tick;
    tick;
    check("d4_c5_366", {colour4_R, colour4_G, colour4_B}, K);
    pix_active = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
